// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, result registered on completion.
// Optional carry-seed input port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CntW-1:0]  r_cnt;
  logic             w_seed;
  logic             w_s;
  logic             w_c;
  logic             w_last;

`ifdef SERIAL_ADDER_CIN_EN
  assign w_seed = cin;
`else
  assign w_seed = 1'b0;
`endif

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_carry & r_a[0]);
  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_seed;
            r_cnt   <= '0;
          end
        end
        StShift: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // Final bit lands in the MSB directly, so publish the assembled word this edge.
          if (w_last) begin
            r_sum  <= {w_s, r_res[WIDTH-1:1]};
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
